// File: rtl/cva6_irq_sequencer.sv
// -----------------------------------------------------------------------------
// cva6_irq_sequencer
//
// Interrupt gateway and arbiter for the two external interrupt inputs of a
// CVA6 core. It samples N_SRC rising-edge interrupt sources and latches them
// as pending. Each source is masked by ENABLE and routed by TARGET to one of
// two contexts:
//   - M-context, driven on irqs_o[0]
//   - S-context, driven on irqs_o[1]
// Software services a source with a claim/complete handshake through a small
// register port. Priority is fixed: the lowest ID wins.
//
// Source numbering: source bit k is interrupt ID k+1. ID 0 means "none".
//
// Optional feature (macro CVA6_IRQ_SYNC_EN):
//   defined   : src_i passes through a 2-flop synchroniser before edge
//               detection, so src_i may be asynchronous to aclk.
//   undefined : src_i feeds edge detection directly and must already be
//               synchronous to aclk.
//
// Ports:
//   aclk          clock
//   aresetn       asynchronous active-low reset
//   src_i         interrupt sources, rising-edge sensitive
//   reg_req_i     register access request, one-cycle pulse per access
//   reg_we_i      1 = write, 0 = read
//   reg_addr_i    byte address, word aligned
//   reg_wdata_i   write data
//   reg_rdata_o   read data, valid while reg_ready_o = 1
//   reg_ready_o   response strobe, one cycle after the request
//   irqs_o        level interrupts to the core: [0] M-context, [1] S-context
//
// Register port handshake:
//   Every cycle with reg_req_i = 1 is an accepted access; there is no
//   back-pressure. All side effects (claim, complete, register writes) happen
//   on the accepting clock edge. reg_ready_o is high for exactly the
//   following cycle, and reg_rdata_o is valid during that cycle. For writes
//   and for unmapped reads, reg_rdata_o is 0.
//
// Register map:
//   0x00 PENDING     read-only
//   0x04 ENABLE      read/write
//   0x08 TARGET      read/write, bit = 1 selects the S-context
//   0x0C CLAIM_M     read = claim, write = complete
//   0x10 CLAIM_S     read = claim, write = complete
//   0x14 IN_SERVICE  read-only
// -----------------------------------------------------------------------------
module cva6_irq_sequencer #(
   parameter int unsigned N_SRC      = 8,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [N_SRC-1:0]      src_i,
   input  logic                  reg_req_i,
   input  logic                  reg_we_i,
   input  logic [ADDR_WIDTH-1:0] reg_addr_i,
   input  logic [31:0]           reg_wdata_i,
   output logic [31:0]           reg_rdata_o,
   output logic                  reg_ready_o,
   output logic [1:0]            irqs_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING = ADDR_WIDTH'(32'h00);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE  = ADDR_WIDTH'(32'h04);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TARGET  = ADDR_WIDTH'(32'h08);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CLAIM_M = ADDR_WIDTH'(32'h0C);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CLAIM_S = ADDR_WIDTH'(32'h10);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INSERV  = ADDR_WIDTH'(32'h14);

   logic [N_SRC-1:0] src_s;
   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] src_edge;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] enable_q, enable_d;
   logic [N_SRC-1:0] target_q, target_d;
   logic [N_SRC-1:0] in_service_q, in_service_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q;
   logic [1:0]       irqs_q, irqs_d;

   logic [N_SRC-1:0] elig_m, elig_s;
   logic [4:0]       claim_id_m, claim_id_s;
   logic [N_SRC-1:0] claim_clr;
   logic [N_SRC-1:0] cmpl_clr;

   logic rd_acc, wr_acc;
   logic claim_m_rd, claim_s_rd;
   logic cmpl_m_wr, cmpl_s_wr;
   logic enable_wr, target_wr;

   // ---------------------------------------------------------------------------
   // Source conditioning and edge detection
   // ---------------------------------------------------------------------------
`ifdef CVA6_IRQ_SYNC_EN
   logic [N_SRC-1:0] sync1_q, sync2_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src_i;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         src_q <= '0;
      end else begin
         src_q <= src_s;
      end
   end

   assign src_edge = src_s & ~src_q;

   // ---------------------------------------------------------------------------
   // Register access decode
   // ---------------------------------------------------------------------------
   assign rd_acc     = reg_req_i & ~reg_we_i;
   assign wr_acc     = reg_req_i &  reg_we_i;
   assign claim_m_rd = rd_acc & (reg_addr_i == ADDR_CLAIM_M);
   assign claim_s_rd = rd_acc & (reg_addr_i == ADDR_CLAIM_S);
   assign cmpl_m_wr  = wr_acc & (reg_addr_i == ADDR_CLAIM_M);
   assign cmpl_s_wr  = wr_acc & (reg_addr_i == ADDR_CLAIM_S);
   assign enable_wr  = wr_acc & (reg_addr_i == ADDR_ENABLE);
   assign target_wr  = wr_acc & (reg_addr_i == ADDR_TARGET);

   // ---------------------------------------------------------------------------
   // Arbitration: lowest eligible ID per context
   // ---------------------------------------------------------------------------
   assign elig_m = pending_q & enable_q & ~target_q;
   assign elig_s = pending_q & enable_q &  target_q;

   // Scans downwards so that the last assignment is the lowest set bit.
   function automatic logic [4:0] lowest_id(input logic [N_SRC-1:0] v);
      logic [4:0] id;
      id = '0;
      for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
         if (v[k]) id = 5'(k + 1);
      end
      return id;
   endfunction

   assign claim_id_m = lowest_id(elig_m);
   assign claim_id_s = lowest_id(elig_s);

   // Claim and complete masks. They are built by comparing against each ID,
   // which avoids indexing with a variable-width ID. A complete is honoured
   // only if the ID is in range, currently in service, and owned by the
   // context being written.
   always_comb begin
      claim_clr = '0;
      cmpl_clr  = '0;
      for (int k = 0; k < int'(N_SRC); k++) begin
         if (claim_m_rd && (claim_id_m == 5'(k + 1))) claim_clr[k] = 1'b1;
         if (claim_s_rd && (claim_id_s == 5'(k + 1))) claim_clr[k] = 1'b1;
         if (cmpl_m_wr && (reg_wdata_i == 32'(k + 1)) && in_service_q[k] && !target_q[k])
            cmpl_clr[k] = 1'b1;
         if (cmpl_s_wr && (reg_wdata_i == 32'(k + 1)) && in_service_q[k] && target_q[k])
            cmpl_clr[k] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // An edge is coalesced if the source is already pending or in service.
      // in_service_q is used deliberately: an edge that arrives in the same
      // cycle as its own complete is dropped.
      pending_d    = (pending_q | (src_edge & ~pending_q & ~in_service_q)) & ~claim_clr;
      in_service_d = (in_service_q | claim_clr) & ~cmpl_clr;
      enable_d     = enable_wr ? reg_wdata_i[N_SRC-1:0] : enable_q;
      target_d     = target_wr ? reg_wdata_i[N_SRC-1:0] : target_q;
      irqs_d       = {|elig_s, |elig_m};

      rdata_d = '0;
      if (rd_acc) begin
         case (reg_addr_i)
            ADDR_PENDING: rdata_d = 32'(pending_q);
            ADDR_ENABLE:  rdata_d = 32'(enable_q);
            ADDR_TARGET:  rdata_d = 32'(target_q);
            ADDR_CLAIM_M: rdata_d = 32'(claim_id_m);
            ADDR_CLAIM_S: rdata_d = 32'(claim_id_s);
            ADDR_INSERV:  rdata_d = 32'(in_service_q);
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pending_q    <= '0;
         enable_q     <= '0;
         target_q     <= '0;
         in_service_q <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         irqs_q       <= '0;
      end else begin
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         target_q     <= target_d;
         in_service_q <= in_service_d;
         rdata_q      <= rdata_d;
         ready_q      <= reg_req_i;
         irqs_q       <= irqs_d;
      end
   end

   assign reg_rdata_o = rdata_q;
   assign reg_ready_o = ready_q;
   assign irqs_o      = irqs_q;

endmodule
